bus_memory_responder: RTL and testbench

Single-port memory responder at the far end of the CPU bus.
- Accepts one address/data/bhw/write_notread request at a time.
- Performs a byte, halfword or word read or write on an internal word array.
- Returns completion with a one-cycle o_bus_DV pulse after a programmable number of wait states.
- Sits between the CPU bus outputs and the CPU's i_bus_data/i_bus_DV inputs; it is the RAM/ROM model used for CPU bring-up.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_lane_align.sv | 42 ++++
 rtl/bus_memory_responder.sv | 126 ++++++++++++
 tb/tb_bus_memory_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: access-size encodings (RISC-V funct3) and responder FSM states.
package bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BHW_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [BHW_W-1:0] BHW_B  = 3'b000;
  localparam logic [BHW_W-1:0] BHW_H  = 3'b001;
  localparam logic [BHW_W-1:0] BHW_W_ = 3'b010;
  localparam logic [BHW_W-1:0] BHW_BU = 3'b100;
  localparam logic [BHW_W-1:0] BHW_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_lane_align.sv
// Little-endian lane steering: merges byte/halfword writes into a word and
// right-justifies plus sign/zero-extends read lanes.
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [BHW_W-1:0]  i_bhw,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_old_word,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_wr_word_c,
  output logic [DATA_W-1:0] o_rd_data_c
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        ext_bit;

  always_comb begin
    rd_byte     = i_old_word[{i_addr_lo, 3'b000} +: 8];
    rd_half     = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];
    ext_bit     = 1'b0;
    o_rd_data_c = i_old_word;
    o_wr_word_c = i_wr_data;
    case (i_bhw)
      BHW_B, BHW_BU: begin
        ext_bit     = rd_byte[7] & ~i_bhw[2];
        o_rd_data_c = {{24{ext_bit}}, rd_byte};
        o_wr_word_c = i_old_word;
        o_wr_word_c[{i_addr_lo, 3'b000} +: 8] = i_wr_data[7:0];
      end
      BHW_H, BHW_HU: begin
        ext_bit     = rd_half[15] & ~i_bhw[2];
        o_rd_data_c = {{16{ext_bit}}, rd_half};
        o_wr_word_c = i_old_word;
        if (i_addr_lo[1]) o_wr_word_c[31:16] = i_wr_data[15:0];
        else              o_wr_word_c[15:0]  = i_wr_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_memory_responder.sv
// Single-port memory responder: one request at a time, programmable wait states,
// one-cycle o_bus_DV completion strobe.
module bus_memory_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_bus_address,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_DV,
  input  logic [BHW_W-1:0]  i_bhw,
  input  logic              i_write_notread,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_DV
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  bus_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BHW_W-1:0]  bhw_q, bhw_d;
  logic              wnr_q, wnr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              dv_q, dv_d;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              capture_c, access_c, in_range_c;
  logic [29:0]       word_off_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] old_word_c, wr_word_c, rd_ext_c;

  assign capture_c  = (state_q == IDLE) && i_bus_DV && armed_q;
  assign access_c   = (state_q == WAIT) && (cnt_q == '0);
  assign word_off_c = 30'((addr_q - BASE_ADDR) >> 2);
  assign in_range_c = (addr_q >= BASE_ADDR) && (word_off_c < 30'(DEPTH_WORDS));
  assign idx_c      = word_off_c[IDX_W-1:0];
  assign old_word_c = mem[idx_c];

  bus_lane_align u_align (
    .i_bhw       (bhw_q),
    .i_addr_lo   (addr_q[1:0]),
    .i_old_word  (old_word_c),
    .i_wr_data   (wdata_q),
    .o_wr_word_c (wr_word_c),
    .o_rd_data_c (rd_ext_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_c) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait countdown, re-arm tracking and response data
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q | ~i_bus_DV;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bhw_d   = bhw_q;
    wnr_d   = wnr_q;
    rdata_d = rdata_q;
    dv_d    = access_c;
    if (capture_c) begin
      armed_d = 1'b0;
      addr_d  = i_bus_address;
      wdata_d = i_bus_data;
      bhw_d   = i_bhw;
      wnr_d   = i_write_notread;
      cnt_d   = CNT_LOAD;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (access_c) rdata_d = (wnr_q || !in_range_c) ? '0 : rd_ext_c;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      bhw_q   <= '0;
      wnr_q   <= 1'b0;
      rdata_q <= '0;
      dv_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bhw_q   <= bhw_d;
      wnr_q   <= wnr_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
    end
  end

  // Array is deliberately not reset; out-of-range writes are dropped
  always_ff @(posedge i_clk) begin
    if (access_c && wnr_q && in_range_c) mem[idx_c] <= wr_word_c;
  end

  assign o_bus_data = rdata_q;
  assign o_bus_DV   = dv_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench: three responders with LATENCY 1, 3 and 4 sharing one clock.
module tb_bus_memory_responder;

  localparam int unsigned NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [NDUT];
  logic [31:0] addr   [NDUT];
  logic [31:0] wdata  [NDUT];
  logic [31:0] rdata  [NDUT];
  logic        dv_in  [NDUT];
  logic        dv_out [NDUT];
  logic        wnr    [NDUT];
  logic [2:0]  bhw    [NDUT];
  int          lat_of [NDUT] = '{1, 3, 4};

  logic [31:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bus_memory_responder #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_WORDS (4096),
      .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .INIT_FILE   ("")
    ) u_dut (
      .i_clk           (clk),
      .i_rst           (rst[g]),
      .i_bus_address   (addr[g]),
      .i_bus_data      (wdata[g]),
      .i_bus_DV        (dv_in[g]),
      .i_bhw           (bhw[g]),
      .i_write_notread (wnr[g]),
      .o_bus_data      (rdata[g]),
      .o_bus_DV        (dv_out[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request; returns just after the capture edge with DV dropped
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] b, input logic w);
    @(negedge clk);
    addr[k] = a; wdata[k] = d; bhw[k] = b; wnr[k] = w; dv_in[k] = 1'b1;
    @(posedge clk);
    #1 dv_in[k] = 1'b0;
  endtask

  task automatic wait_resp(input int k, input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (n < 40 && dv_out[k] !== 1'b1) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat_of[k]));
    if (dv_out[k] === 1'b1) begin
      chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_data"}, rdata[k], e);
      end
      @(posedge clk);
      #1 chk({tag, "_dv1cyc"}, 32'(dv_out[k]), 32'd0);
    end
    sb.delete();
  endtask

  task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] b, input logic w, input logic [31:0] exp,
                     input string tag);
    sb.push_back(exp);
    issue(k, a, d, b, w);
    wait_resp(k, tag);
  endtask

  initial begin
    int pulses, pos;
    logic [31:0] e;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; addr[k] = '0; wdata[k] = '0; dv_in[k] = 1'b0;
      wnr[k] = 1'b0; bhw[k] = 3'b010;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_dv", 32'(dv_out[k]), 32'd0);
      chk("rst_data", rdata[k], 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;

    // Word write/read, LATENCY=1
    txn(0, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 32'h0, "sw10");
    txn(0, 32'h10, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF, "lw10");

    // Sign/zero-extended loads
    txn(0, 32'h10, 32'h8081F0F1, 3'b010, 1'b1, 32'h0, "sw_ext");
    txn(0, 32'h13, 32'h0, 3'b000, 1'b0, 32'hFFFFFF80, "lb13");
    txn(0, 32'h13, 32'h0, 3'b100, 1'b0, 32'h00000080, "lbu13");
    txn(0, 32'h10, 32'h0, 3'b001, 1'b0, 32'hFFFFF0F1, "lh10");
    txn(0, 32'h12, 32'h0, 3'b101, 1'b0, 32'h00008081, "lhu12");

    // Partial writes only touch their lane
    txn(0, 32'h10, 32'h11223344, 3'b010, 1'b1, 32'h0, "sw_part");
    txn(0, 32'h11, 32'h000000AA, 3'b000, 1'b1, 32'h0, "sb11");
    txn(0, 32'h10, 32'h0,        3'b010, 1'b0, 32'h1122AA44, "lw_sb");
    txn(0, 32'h12, 32'h00005566, 3'b001, 1'b1, 32'h0, "sh12");
    txn(0, 32'h10, 32'h0,        3'b010, 1'b0, 32'h5566AA44, "lw_sh");

    // Out of range
    txn(0, 32'h0,        32'hCAFEF00D, 3'b010, 1'b1, 32'h0, "sw0");
    txn(0, 32'h10,       32'h0,        3'b010, 1'b0, 32'h5566AA44, "lw_nz");
    txn(0, 32'h00010000, 32'h0,        3'b010, 1'b0, 32'h0, "lw_oor");
    txn(0, 32'h00010000, 32'h12345678, 3'b010, 1'b1, 32'h0, "sw_oor");
    txn(0, 32'h0,        32'h0,        3'b010, 1'b0, 32'hCAFEF00D, "lw0");

    // Reset mid-WAIT, LATENCY=3
    txn(1, 32'h10, 32'h01020304, 3'b010, 1'b1, 32'h0, "l3_sw");
    txn(1, 32'h10, 32'h0,        3'b010, 1'b0, 32'h01020304, "l3_lw");
    issue(1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
    @(posedge clk);
    #1 rst[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (dv_out[1] === 1'b1) pulses++;
    end
    chk("rstw_nodv", 32'(pulses), 32'd0);
    chk("rstw_data", rdata[1], 32'd0);
    txn(1, 32'h10, 32'h0, 3'b010, 1'b0, 32'h01020304, "rstw_lw");

    // DV held high, LATENCY=4: one response, then re-arm
    txn(2, 32'h20, 32'h0BADC0DE, 3'b010, 1'b1, 32'h0, "l4_sw");
    sb.push_back(32'h0BADC0DE);
    @(negedge clk);
    addr[2] = 32'h20; bhw[2] = 3'b010; wnr[2] = 1'b0; dv_in[2] = 1'b1;
    pulses = 0;
    pos = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (dv_out[2] === 1'b1) begin
        pulses++;
        if (pos < 0) begin
          pos = i;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hold_data", rdata[2], e);
          end
        end
      end
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    chk("hold_pos", 32'(pos), 32'd4);
    sb.delete();
    @(negedge clk);
    dv_in[2] = 1'b0;
    txn(2, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0BADC0DE, "rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
